// File: rtl/heartbeat_sensor_emu.sv
// SPI mode-0 responder emulating the 12-bit ADC Pmod: each frame sends leading
// zeros and then one sample, MSB first. Samples arrive on a valid/ready port.
module heartbeat_sensor_emu #(
    parameter int FRAME_BITS  = 16,
    parameter int DATA_BITS   = 12,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                 sysCLK,
    input  logic                 reset,
    input  logic                 spi_csN,
    input  logic                 spi_sclk,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    input  logic [DATA_BITS-1:0] smp_data,
    input  logic                 smp_valid,
    output logic                 smp_ready,
    output logic                 frame_done,
    output logic                 frame_abort,
    output logic [CNT_W-1:0]     stale_count
);
    localparam int BCNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync;
    logic                   cs_q, sclk_q;
    logic                   cs_s, sclk_s;
    logic                   cs_fall, cs_rise, sclk_rise, sclk_fall;

    logic [FRAME_BITS-1:0]  shreg;
    logic [BCNT_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0]   hold_q, last_sent, load_val;
    logic                   full, hs;
    logic                   load, cnt_inc, shift_en, done_p, abort_p;

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_q & ~cs_s;
    assign cs_rise   = ~cs_q & cs_s;
    assign sclk_rise = ~sclk_q & sclk_s;
    assign sclk_fall = sclk_q & ~sclk_s;

    // Synchronizers idle at the bus-idle levels so reset never looks like an edge.
    always_ff @(posedge sysCLK) begin
        if (reset) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
        end else begin
            cs_sync   <= (cs_sync << 1) | SYNC_STAGES'(spi_csN);
            sclk_sync <= (sclk_sync << 1) | SYNC_STAGES'(spi_sclk);
            cs_q      <= cs_s;
            sclk_q    <= sclk_s;
        end
    end

    always_ff @(posedge sysCLK) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        cnt_inc  = 1'b0;
        shift_en = 1'b0;
        done_p   = 1'b0;
        abort_p  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    abort_p  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    shift_en = sclk_fall;
                    if (sclk_rise) begin
                        cnt_inc = 1'b1;
                        if (bit_cnt == BCNT_W'(FRAME_BITS - 1)) begin
                            done_p   = 1'b1;
                            state_nx = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (cs_rise) state_nx = IDLE;
                else         shift_en = sclk_fall;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign smp_ready = ~full;
    assign hs        = smp_valid & ~full;

    // Held sample wins, then a same-cycle bypass, else the previous word again.
    always_comb begin
        if (full)    load_val = hold_q;
        else if (hs) load_val = smp_data;
        else         load_val = last_sent;
    end

    always_ff @(posedge sysCLK) begin
        if (reset) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            hold_q      <= '0;
            last_sent   <= '0;
            full        <= 1'b0;
            stale_count <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_done  <= done_p;
            frame_abort <= abort_p;
            if (load) begin
                shreg     <= FRAME_BITS'(load_val);
                last_sent <= load_val;
                bit_cnt   <= '0;
                if (full)
                    full <= 1'b0;
                else if (!hs && stale_count != '1)
                    stale_count <= stale_count + 1'b1;
            end else begin
                if (hs) begin
                    hold_q <= smp_data;
                    full   <= 1'b1;
                end
                if (shift_en) shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                if (cnt_inc)  bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign spi_miso_oe = (state != IDLE);
    assign spi_miso    = spi_miso_oe & shreg[FRAME_BITS-1];

endmodule

// File: tb/tb_heartbeat_sensor_emu.sv
// Bench for heartbeat_sensor_emu: acts as SPI master at sysCLK/8, offers samples,
// and checks captured frames against a vector table, hand sequences and a model.
module tb_heartbeat_sensor_emu;
    localparam int SYNC = 2;

    logic        sysCLK = 1'b0;
    logic        reset, spi_csN, spi_sclk, spi_miso, spi_miso_oe;
    logic [11:0] smp_data;
    logic        smp_valid, smp_ready, frame_done, frame_abort;
    logic [7:0]  stale_count;

    int nerr = 0, nchk = 0;
    int n_done = 0, n_abort = 0;

    // Reference model state: one-entry holding slot, last sent word, stale count.
    bit         m_has;
    logic [11:0] m_val, m_last;
    int         m_stale;

    heartbeat_sensor_emu #(.FRAME_BITS(16), .DATA_BITS(12), .SYNC_STAGES(SYNC), .CNT_W(8)) dut (
        .sysCLK(sysCLK), .reset(reset), .spi_csN(spi_csN), .spi_sclk(spi_sclk),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .smp_data(smp_data),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .frame_done(frame_done),
        .frame_abort(frame_abort), .stale_count(stale_count)
    );

    always #5 sysCLK = ~sysCLK;

    always @(negedge sysCLK) begin
        if (frame_done)  n_done++;
        if (frame_abort) n_abort++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic offer(input logic [11:0] d, input bit exp_rdy);
        chk("smp_ready_before_offer", smp_ready, exp_rdy);
        smp_data  = d;
        smp_valid = 1'b1;
        @(negedge sysCLK);
        smp_valid = 1'b0;
        @(negedge sysCLK);
    endtask

    // One frame of nbits SCLK periods; nbits<16 raises CS early (abort).
    task automatic frame_chk(input string tag, input int nbits, input bit byp,
                             input logic [11:0] bv, input logic [15:0] ecap,
                             input logic [7:0] estale, input bit erdy);
        logic [15:0] cap;
        int d0, a0;
        cap = '0;
        d0 = n_done;
        a0 = n_abort;
        spi_csN = 1'b0;
        if (byp) begin
            repeat (SYNC) @(negedge sysCLK);
            smp_data  = bv;
            smp_valid = 1'b1;
            @(negedge sysCLK);
            smp_valid = 1'b0;
            repeat (5) @(negedge sysCLK);
        end else begin
            repeat (8) @(negedge sysCLK);
        end
        chk({tag, "_oe_active"}, spi_miso_oe, 1'b1);
        for (int i = 0; i < nbits; i++) begin
            cap = {cap[14:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (4) @(negedge sysCLK);
            spi_sclk = 1'b0;
            repeat (4) @(negedge sysCLK);
        end
        spi_csN = 1'b1;
        repeat (6) @(negedge sysCLK);
        chk({tag, "_cap"}, cap, ecap);
        chk({tag, "_oe_release"}, spi_miso_oe, 1'b0);
        chk({tag, "_stale"}, stale_count, estale);
        chk({tag, "_done_pulses"}, n_done - d0, (nbits == 16) ? 1 : 0);
        chk({tag, "_abort_pulses"}, n_abort - a0, (nbits == 16) ? 0 : 1);
        chk({tag, "_ready_after"}, smp_ready, erdy);
    endtask

    typedef struct {
        bit          offer;
        bit          byp;
        logic [11:0] d;
        int          nbits;
        logic [15:0] cap;
        logic [7:0]  stale;
        bit          rdy;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [15:0] word;
        int nb;
        bit byp;
        logic [11:0] d;

        vt[0] = '{1'b1, 1'b0, 12'hABC, 16, 16'h0ABC, 8'd0, 1'b1};
        vt[1] = '{1'b0, 1'b0, 12'h000, 16, 16'h0ABC, 8'd1, 1'b1};
        vt[2] = '{1'b0, 1'b0, 12'h000, 16, 16'h0ABC, 8'd2, 1'b1};
        vt[3] = '{1'b0, 1'b1, 12'h123, 16, 16'h0123, 8'd2, 1'b1};
        vt[4] = '{1'b1, 1'b0, 12'h456,  7, 16'h0002, 8'd2, 1'b1};
        vt[5] = '{1'b0, 1'b0, 12'h000, 16, 16'h0456, 8'd3, 1'b1};

        reset = 1'b1; spi_csN = 1'b1; spi_sclk = 1'b0;
        smp_data = '0; smp_valid = 1'b0;
        repeat (3) @(negedge sysCLK);
        chk("rst_miso", spi_miso, 1'b0);
        chk("rst_oe", spi_miso_oe, 1'b0);
        chk("rst_ready", smp_ready, 1'b1);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_abort", frame_abort, 1'b0);
        chk("rst_stale", stale_count, 8'd0);
        reset = 1'b0;
        repeat (4) @(negedge sysCLK);

        for (int i = 0; i < 6; i++) begin
            if (vt[i].offer) offer(vt[i].d, 1'b1);
            frame_chk($sformatf("vec%0d", i), vt[i].nbits, vt[i].byp, vt[i].d,
                      vt[i].cap, vt[i].stale, vt[i].rdy);
        end

        // Back-pressure: second sample waits until the first is loaded.
        offer(12'h555, 1'b1);
        smp_data = 12'h777; smp_valid = 1'b1;
        repeat (3) @(negedge sysCLK);
        chk("bp_ready_low", smp_ready, 1'b0);
        frame_chk("bp_first", 16, 1'b0, 12'h000, 16'h0555, 8'd3, 1'b0);
        smp_valid = 1'b0;
        frame_chk("bp_second", 16, 1'b0, 12'h000, 16'h0777, 8'd3, 1'b1);

        // Reset at bit 9 with a sample sitting in the holding register.
        spi_csN = 1'b0;
        repeat (8) @(negedge sysCLK);
        smp_data = 12'h999; smp_valid = 1'b1;
        @(negedge sysCLK);
        smp_valid = 1'b0;
        @(negedge sysCLK);
        chk("mid_ready_low", smp_ready, 1'b0);
        for (int i = 0; i < 9; i++) begin
            spi_sclk = 1'b1; repeat (4) @(negedge sysCLK);
            spi_sclk = 1'b0; repeat (4) @(negedge sysCLK);
        end
        spi_sclk = 1'b1; repeat (2) @(negedge sysCLK);
        reset = 1'b1; spi_csN = 1'b1; spi_sclk = 1'b0;
        @(negedge sysCLK);
        chk("mid_rst_miso", spi_miso, 1'b0);
        chk("mid_rst_oe", spi_miso_oe, 1'b0);
        chk("mid_rst_ready", smp_ready, 1'b1);
        chk("mid_rst_stale", stale_count, 8'd0);
        chk("mid_rst_done", frame_done, 1'b0);
        chk("mid_rst_abort", frame_abort, 1'b0);
        repeat (3) @(negedge sysCLK);
        reset = 1'b0;
        repeat (4) @(negedge sysCLK);
        frame_chk("post_rst", 16, 1'b0, 12'h000, 16'h0000, 8'd1, 1'b1);

        // Randomized traffic against the model.
        m_has = 1'b0; m_val = '0; m_last = '0; m_stale = 1;
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                d = 12'($urandom);
                offer(d, !m_has);
                if (!m_has) begin m_has = 1'b1; m_val = d; end
                if ($urandom_range(0, 3) == 0) offer(12'($urandom), 1'b0);
            end
            nb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
            byp = !m_has && ($urandom_range(0, 3) == 0);
            d   = 12'($urandom);
            if (m_has) begin
                m_last = m_val; m_has = 1'b0;
            end else if (byp) begin
                m_last = d;
            end else begin
                if (m_stale < 255) m_stale++;
            end
            word = {4'h0, m_last};
            frame_chk($sformatf("rnd%0d", it), nb, byp, d, word >> (16 - nb),
                      8'(m_stale), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
